wb_bus_arbiter: RTL and testbench

Shares the single physical-register-file write port, ready-table set port and ROB complete broadcast among the functional units that produce results: ALU_0, ALU_1 and LQ. Each requester hands off one result through a valid/ready handshake into a private one-entry holding buffer. A round-robin arbiter moves one buffered result per cycle into a registered writeback stage that drains under a downstream ready. The block sits between the execute-side units and the reg file / ready table / ROB.

---
 rtl/core_types_pkg.sv | 32 +++
 rtl/wb_bus_arbiter_rr_arbiter.sv | 54 +++++
 rtl/wb_bus_arbiter.sv | 128 ++++++++++++
 tb/tb_wb_bus_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_types_pkg.sv
// Shared core types: register tags, data words, ROB indices and the writeback-arbiter
// request types used by wb_bus_arbiter and its rr_arbiter sub-module.
package core_types_pkg;

    localparam int PHYS_REG_TAG_W = 6;
    localparam int WORD_W         = 32;
    localparam int ROB_INDEX_W    = 5;

    typedef logic [PHYS_REG_TAG_W-1:0] phys_reg_tag_t;
    typedef logic [WORD_W-1:0]         word_t;
    typedef logic [ROB_INDEX_W-1:0]    ROB_index_t;

    localparam int WB_NUM_REQ = 3;

    typedef enum logic [1:0] {
        WB_ALU_0 = 2'd0,
        WB_ALU_1 = 2'd1,
        WB_LQ    = 2'd2
    } wb_source_t;

    typedef struct packed {
        phys_reg_tag_t phys_reg_tag;
        word_t         data;
        ROB_index_t    ROB_index;
    } wb_req_struct_t;

    // Index following idx in a ring of n entries.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/wb_bus_arbiter_rr_arbiter.sv
// Combinational arbiter: searches req from a start index, wrapping, and grants the first hit.
// Round-robin starts after rr_ptr; fixed-priority starts at FIXED_FIRST and ignores rr_ptr.
module rr_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter bit ROUND_ROBIN = 1'b1,
    parameter int FIXED_FIRST = NUM_REQ - 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0]   start_idx;
    logic [NUM_REQ-1:0] grant_raw;
    logic [IDX_W-1:0]   idx_raw;
    logic               found;
    logic [IDX_W:0]     cand;

    generate
        if (ROUND_ROBIN) begin : g_round_robin
            assign start_idx = (int'(rr_ptr) >= NUM_REQ - 1) ? '0 : rr_ptr + 1'b1;
        end else begin : g_fixed_priority
            logic unused_rr_ptr;
            assign unused_rr_ptr = ^rr_ptr;
            assign start_idx     = IDX_W'(FIXED_FIRST);
        end
    endgenerate

    // One extra bit on cand keeps start + offset from overflowing before the wrap.
    always_comb begin
        grant_raw = '0;
        idx_raw   = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, start_idx} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!found && req[cand[IDX_W-1:0]]) begin
                found                         = 1'b1;
                grant_raw[cand[IDX_W-1:0]]    = 1'b1;
                idx_raw                       = cand[IDX_W-1:0];
            end
        end
    end

    assign grant     = advance ? grant_raw : '0;
    assign grant_idx = idx_raw;

endmodule

// File: rtl/wb_bus_arbiter.sv
// Writeback arbiter: one holding buffer per result producer feeding a registered writeback stage.
// Define WB_ARB_ROUND_ROBIN_EN for round-robin; otherwise fixed priority LQ > ALU_0 > ALU_1.
module wb_bus_arbiter
    import core_types_pkg::*;
#(
    parameter int NUM_REQ = WB_NUM_REQ
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  phys_reg_tag_t [NUM_REQ-1:0]  req_phys_reg_tag,
    input  word_t [NUM_REQ-1:0]          req_data,
    input  ROB_index_t [NUM_REQ-1:0]     req_ROB_index,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic                         flush,
    input  logic                         wb_ready,
    output logic                         wb_valid,
    output phys_reg_tag_t                wb_phys_reg_tag,
    output word_t                        wb_data,
    output ROB_index_t                   wb_ROB_index,
    output logic [$clog2(NUM_REQ)-1:0]   wb_source
);

    localparam int SRC_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] buf_valid_reg;
    wb_req_struct_t     buf_payload_reg [NUM_REQ];
    logic [NUM_REQ-1:0] grant;
    logic [SRC_W-1:0]   grant_idx;
    logic [SRC_W-1:0]   rr_ptr;
    logic               out_load;
    logic               wb_valid_reg;
    wb_req_struct_t     wb_payload_reg;
    logic [SRC_W-1:0]   wb_source_reg;

    assign out_load = !wb_valid_reg || wb_ready;

`ifdef WB_ARB_ROUND_ROBIN_EN
    localparam bit ROUND_ROBIN = 1'b1;
    logic [SRC_W-1:0] rr_ptr_reg;

    // Reset to the last index so requester 0 is searched first.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rr_ptr_reg <= SRC_W'(NUM_REQ - 1);
        end else if (!flush && out_load && (|grant)) begin
            rr_ptr_reg <= grant_idx;
        end
    end
    assign rr_ptr = rr_ptr_reg;
`else
    localparam bit ROUND_ROBIN = 1'b0;
    assign rr_ptr = '0;
`endif

    // In fixed mode the search starts at the last index (LQ) and wraps to ALU_0, ALU_1.
    rr_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .IDX_W       (SRC_W),
        .ROUND_ROBIN (ROUND_ROBIN),
        .FIXED_FIRST (NUM_REQ - 1)
    ) u_arbiter (
        .req       (buf_valid_reg),
        .rr_ptr    (rr_ptr),
        .advance   (out_load),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // grant is already qualified by out_load, so a granted buffer frees up this edge.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = !flush && (!buf_valid_reg[gi] || grant[gi]);
        end
    endgenerate

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            buf_valid_reg <= '0;
        end else if (flush) begin
            buf_valid_reg <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    buf_valid_reg[i] <= 1'b1;
                end else if (grant[i]) begin
                    buf_valid_reg[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                buf_payload_reg[i] <= '{phys_reg_tag: req_phys_reg_tag[i],
                                        data:         req_data[i],
                                        ROB_index:    req_ROB_index[i]};
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wb_valid_reg   <= 1'b0;
            wb_payload_reg <= '0;
            wb_source_reg  <= '0;
        end else if (flush) begin
            wb_valid_reg <= 1'b0;
        end else if (out_load) begin
            if (|grant) begin
                wb_valid_reg   <= 1'b1;
                wb_payload_reg <= buf_payload_reg[grant_idx];
                wb_source_reg  <= grant_idx;
            end else begin
                wb_valid_reg <= 1'b0;
            end
        end
    end

    assign wb_valid        = wb_valid_reg;
    assign wb_phys_reg_tag = wb_payload_reg.phys_reg_tag;
    assign wb_data         = wb_payload_reg.data;
    assign wb_ROB_index    = wb_payload_reg.ROB_index;
    assign wb_source       = wb_source_reg;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Bench for wb_bus_arbiter: directed scenarios plus random traffic against a per-cycle
// reference model of buffers, writeback stage and grant order.
module tb_wb_bus_arbiter;
    import core_types_pkg::*;

    localparam int N = WB_NUM_REQ;
`ifdef WB_ARB_ROUND_ROBIN_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic                  CLK = 1'b0;
    logic                  nRST;
    logic [N-1:0]          req_valid;
    phys_reg_tag_t [N-1:0] req_phys_reg_tag;
    word_t [N-1:0]         req_data;
    ROB_index_t [N-1:0]    req_ROB_index;
    logic [N-1:0]          req_ready;
    logic                  flush;
    logic                  wb_ready;
    logic                  wb_valid;
    phys_reg_tag_t         wb_phys_reg_tag;
    word_t                 wb_data;
    ROB_index_t            wb_ROB_index;
    logic [$clog2(N)-1:0]  wb_source;

    wb_bus_arbiter #(.NUM_REQ(N)) dut (
        .CLK              (CLK),
        .nRST             (nRST),
        .req_valid        (req_valid),
        .req_phys_reg_tag (req_phys_reg_tag),
        .req_data         (req_data),
        .req_ROB_index    (req_ROB_index),
        .req_ready        (req_ready),
        .flush            (flush),
        .wb_ready         (wb_ready),
        .wb_valid         (wb_valid),
        .wb_phys_reg_tag  (wb_phys_reg_tag),
        .wb_data          (wb_data),
        .wb_ROB_index     (wb_ROB_index),
        .wb_source        (wb_source)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic          m_bv    [N];
    phys_reg_tag_t m_btag  [N];
    word_t         m_bdata [N];
    ROB_index_t    m_brob  [N];
    logic          m_wv;
    phys_reg_tag_t m_wtag;
    word_t         m_wdata;
    ROB_index_t    m_wrob;
    int            m_wsrc;
    int            m_last;

    int           wb_handshakes;
    int           obs_src [$];
    logic [N-1:0] last_ready;

    // Fixed priority ranks: LQ first, then ALU_0, then ALU_1.
    int fixed_rank [N] = '{1, 2, 0};
    int rr_order   [3] = '{0, 1, 2};
    int fx_order   [3] = '{2, 0, 1};

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=0x%0h exp=0x%0h", tag, $time, got, exp);
        end
    endtask

    function automatic int model_pick();
        int best      = -1;
        int best_rank = N;
        int rank;
        for (int i = 0; i < N; i++) begin
            if (m_bv[i]) begin
                rank = RR_MODE ? ((i - m_last - 1 + 2 * N) % N) : fixed_rank[i];
                if (rank < best_rank) begin
                    best_rank = rank;
                    best      = i;
                end
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_bv[i] = 1'b0;
        m_wv    = 1'b0;
        m_wtag  = '0;
        m_wdata = '0;
        m_wrob  = '0;
        m_wsrc  = 0;
        m_last  = N - 1;
    endtask

    task automatic apply_reset();
        req_valid = '0;
        flush     = 1'b0;
        wb_ready  = 1'b1;
        #2;
        nRST = 1'b0;
        #1;
        model_reset();
        check_val("rst_wb_valid", wb_valid, 1'b0);
        check_val("rst_wb_tag", wb_phys_reg_tag, '0);
        check_val("rst_wb_data", wb_data, '0);
        check_val("rst_wb_rob", wb_ROB_index, '0);
        check_val("rst_wb_source", wb_source, '0);
        check_val("rst_req_ready", req_ready, {N{1'b1}});
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic step(input logic [N-1:0] v, input logic fl, input logic wr, input bit rnd);
        int           win;
        logic         load;
        logic [N-1:0] exp_ready;
        @(negedge CLK);
        req_valid = v;
        flush     = fl;
        wb_ready  = wr;
        if (rnd) begin
            for (int i = 0; i < N; i++) begin
                req_phys_reg_tag[i] = phys_reg_tag_t'($urandom);
                req_data[i]         = word_t'($urandom);
                req_ROB_index[i]    = ROB_index_t'($urandom);
            end
        end
        #1;
        load = !m_wv || wr;
        win  = load ? model_pick() : -1;
        for (int i = 0; i < N; i++) exp_ready[i] = !fl && (!m_bv[i] || win == i);
        last_ready = req_ready;
        check_val("req_ready", req_ready, exp_ready);
        if (wb_valid && wb_ready) begin
            wb_handshakes++;
            obs_src.push_back(int'(wb_source));
            $display("wb t=%0t src=%0d tag=0x%0h data=0x%0h rob=0x%0h",
                     $time, wb_source, wb_phys_reg_tag, wb_data, wb_ROB_index);
        end
        @(posedge CLK);
        if (fl) begin
            for (int i = 0; i < N; i++) m_bv[i] = 1'b0;
            m_wv = 1'b0;
        end else begin
            if (load) begin
                if (win >= 0) begin
                    m_wv    = 1'b1;
                    m_wtag  = m_btag[win];
                    m_wdata = m_bdata[win];
                    m_wrob  = m_brob[win];
                    m_wsrc  = win;
                    m_last  = win;
                end else begin
                    m_wv = 1'b0;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (v[i] && exp_ready[i]) begin
                    m_bv[i]    = 1'b1;
                    m_btag[i]  = req_phys_reg_tag[i];
                    m_bdata[i] = req_data[i];
                    m_brob[i]  = req_ROB_index[i];
                end else if (win == i) begin
                    m_bv[i] = 1'b0;
                end
            end
        end
        #1;
        check_val("wb_valid", wb_valid, m_wv);
        if (m_wv) begin
            check_val("wb_tag", wb_phys_reg_tag, m_wtag);
            check_val("wb_data", wb_data, m_wdata);
            check_val("wb_rob", wb_ROB_index, m_wrob);
            check_val("wb_source", wb_source, m_wsrc);
        end
    endtask

    task automatic check_order(input string tag);
        check_val({tag, "_count"}, obs_src.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (obs_src.size() > k) begin
                check_val(tag, obs_src[k], RR_MODE ? rr_order[k] : fx_order[k]);
            end
        end
    endtask

    initial begin
        nRST             = 1'b1;
        req_valid        = '0;
        flush            = 1'b0;
        wb_ready         = 1'b1;
        req_phys_reg_tag = '0;
        req_data         = '0;
        req_ROB_index    = '0;
        wb_handshakes    = 0;
        model_reset();
        apply_reset();

        // Single request from ALU_0
        req_phys_reg_tag[0] = 6'd5;
        req_data[0]         = 32'hDEADBEEF;
        req_ROB_index[0]    = 5'd3;
        step(3'b001, 1'b0, 1'b1, 1'b0);
        step(3'b000, 1'b0, 1'b1, 1'b0);
        check_val("single_valid", wb_valid, 1'b1);
        check_val("single_tag", wb_phys_reg_tag, 6'd5);
        check_val("single_data", wb_data, 32'hDEADBEEF);
        check_val("single_rob", wb_ROB_index, 5'd3);
        check_val("single_src", wb_source, 2'd0);

        // Three-way contention from reset
        apply_reset();
        obs_src.delete();
        step(3'b111, 1'b0, 1'b1, 1'b1);
        repeat (4) step(3'b000, 1'b0, 1'b1, 1'b1);
        check_order("contend_order");

        // Continuous traffic: every granted buffer refills on the same edge
        apply_reset();
        obs_src.delete();
        repeat (8) step(3'b111, 1'b0, 1'b1, 1'b1);
        check_val("cont_count", obs_src.size(), 6);
        for (int k = 0; k < 6; k++) begin
            if (obs_src.size() > k) check_val("cont_order", obs_src[k], RR_MODE ? (k % 3) : 2);
        end

        // Backpressure: everything full, downstream stalled
        apply_reset();
        wb_handshakes = 0;
        step(3'b111, 1'b0, 1'b0, 1'b1);
        step(3'b111, 1'b0, 1'b0, 1'b1);
        repeat (4) begin
            step(3'b000, 1'b0, 1'b0, 1'b1);
            check_val("bp_ready", last_ready, '0);
        end
        repeat (6) step(3'b000, 1'b0, 1'b1, 1'b1);
        check_val("bp_drained", wb_handshakes, 4);

        // Same-edge drain and refill on ALU_1
        apply_reset();
        req_phys_reg_tag[1] = 6'd7;
        step(3'b010, 1'b0, 1'b1, 1'b0);
        req_phys_reg_tag[1] = 6'd9;
        step(3'b010, 1'b0, 1'b1, 1'b0);
        check_val("refill_first_tag", wb_phys_reg_tag, 6'd7);
        check_val("refill_ready", last_ready[1], 1'b1);
        step(3'b000, 1'b0, 1'b1, 1'b0);
        check_val("refill_valid", wb_valid, 1'b1);
        check_val("refill_tag", wb_phys_reg_tag, 6'd9);
        check_val("refill_src", wb_source, 2'd1);

        // Flush with buffers and writeback stage full
        apply_reset();
        step(3'b111, 1'b0, 1'b0, 1'b1);
        step(3'b111, 1'b0, 1'b0, 1'b1);
        step(3'b111, 1'b1, 1'b0, 1'b1);
        check_val("flush_ready", last_ready, '0);
        check_val("flush_wb_valid", wb_valid, 1'b0);
        step(3'b000, 1'b0, 1'b1, 1'b1);
        check_val("post_flush_ready", last_ready, {N{1'b1}});
        check_val("post_flush_wb_valid", wb_valid, 1'b0);

        // Asynchronous reset in the middle of traffic
        repeat (3) step(3'b111, 1'b0, 1'b1, 1'b1);
        check_val("pre_rst_wb_valid", wb_valid, 1'b1);
        apply_reset();
        obs_src.delete();
        step(3'b111, 1'b0, 1'b1, 1'b1);
        repeat (4) step(3'b000, 1'b0, 1'b1, 1'b1);
        check_order("post_rst_order");

        // Random traffic
        apply_reset();
        for (int c = 0; c < 300; c++) begin
            step(N'($urandom_range(0, (1 << N) - 1)),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 9) < 7),
                 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
